dcache_sa_controller: RTL and testbench
=======================================

// Module: dcache_sa_controller
// PURPOSE
//   Parametrised N-way set-associative, write-back, write-allocate data cache controller for the MEM stage.
//   Sits between the EX/MEM pipe register and the 256-bit line memory.
//   Successor to the direct-mapped controller: configurable ways and sets, per-set LRU replacement, dirty-victim writeback.
//   Stalls the whole pipeline through cpu_stall_o while a miss is being serviced.
// PARAMETERS
//   ADDR_W     32   byte address width
//   DATA_W     32   CPU word width
//   LINE_W     256  line width in bits; equals memory bus width
//   NUM_WAYS   2    associativity; power of two, 1..8
//   NUM_SETS   16   set count; power of two, >=2
// PORTS
//   clk_i           in   1          clock
//   rst_i           in   1          reset, asynchronous, active-low
//   cpu_addr_i      in   ADDR_W     byte address (word-aligned)
//   cpu_data_i      in   DATA_W     store data
//   cpu_MemRead_i   in   1          load request
//   cpu_MemWrite_i  in   1          store request
//   cpu_data_o      out  DATA_W     load data
//   cpu_stall_o     out  1          pipeline freeze
//   mem_data_i      in   LINE_W     refill line
//   mem_ack_i       in   1          memory done, one-cycle pulse
//   mem_data_o      out  LINE_W     victim line
//   mem_addr_o      out  ADDR_W     line-aligned memory address
//   mem_enable_o    out  1          memory request
//   mem_write_o     out  1          1 = writeback, 0 = refill
// BEHAVIOUR
//   Address split: offset = log2(LINE_W/8), index = log2(NUM_SETS), tag = the remaining high bits.
//   Request: req = MemRead | MemWrite. If both are high, the access is treated as a store.
//   Hit: one or more ways are valid with a matching tag; lowest matching way wins.
//   Hit timing: zero-latency and combinational.
//     cpu_data_o carries the selected word in the same cycle.
//     cpu_stall_o stays 0.
//     A store hit updates the word and sets dirty at the clock edge.
//   Miss: cpu_stall_o rises combinationally in the same cycle.
//     Victim = first invalid way, else the LRU way. Victim is latched on the IDLE->next edge.
//   FSM states and transitions:
//     IDLE:  on miss, go to WB if victim dirty, else go to FILL.
//     WB:    mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line.
//            Hold until mem_ack_i, then go to FILL.
//     FILL:  mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,0}.
//            On mem_ack_i: write line, valid=1, dirty=0, tag=req tag; go to UPD.
//     UPD:   lookup repeats and now hits; store merge and dirty set occur here.
//            cpu_stall_o drops in this cycle; return to IDLE.
//   Outputs are held stable while mem_enable_o=1. cpu_addr_i/cpu_data_i must stay stable while stalled.
//   mem_ack_i outside WB/FILL is ignored.
//   Miss latency with clean victim: memory ack delay + 1 cycle.
//   LRU: per-set age counters, log2(NUM_WAYS) bits per way.
//     On every hit (including the UPD hit), the touched way goes to age 0.
//     Ways younger than its previous age are incremented. Ages stay a permutation of 0..NUM_WAYS-1.
//     LRU way = the way holding age NUM_WAYS-1.
//     NUM_WAYS=1: LRU logic is absent and way 0 is always the victim.
//   Reset (rst_i=0, any state, including mid-miss): state=IDLE.
//     All valid/dirty bits = 0; ages = way index.
//     cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
//     Any in-flight memory transaction is abandoned.
//   No request in IDLE: no state change; cpu_data_o=0.
// STRUCTURE
//   dcache_pkg holds:
//     state encoding IDLE/WB/FILL/UPD;
//     width functions for offset/index/tag/age;
//     the word-select and line-merge helper functions.
//   Sub-module dcache_way_array, one instance per way (generate), holds:
//     tag, valid, dirty and data storage;
//     a combinational read port and a single write port (full-line or word-merge).
//   The top level keeps the FSM, hit/way select, LRU ages and memory interface.
// TESTING
//   Defaults used throughout; the memory model acks 4 cycles after enable.
//   1. Cold load 0x0000_0040: stall lasts 5 cycles, FILL addr 0x40, mem_write_o=0.
//      A repeat load hits with stall=0 and returns the memory word.
//   2. Store 0xDEADBEEF to 0x44 on a hit: no stall, line dirty.
//      A load from 0x44 returns 0xDEADBEEF.
//   3. Conflict loads 0x040, 0x240 (same set, fills ways 0 and 1), then 0x440 evicts way 0 (the LRU).
//      Dirty way 0 causes a WB to addr 0x040 carrying 0xDEADBEEF, then a FILL of 0x440.
//   4. LRU update: load 0x040, 0x240, reload 0x040, then miss 0x440.
//      Way 1 (0x240) is evicted; a later load from 0x040 still hits.
//   5. Reset asserted in the 2nd cycle of FILL: all outputs 0 immediately.
//      After release, a load from the same address misses again with a full refill.
//   6. Simultaneous MemRead=MemWrite=1 to 0x80 with data 0x12345678: treated as a store.
//      A later load returns 0x12345678.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
// Width helpers are constant functions; word helpers work on max-width vectors.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    localparam int MAX_LINE_W = 1024;
    localparam int MAX_DATA_W = 64;

    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w, input int num_sets);
        return addr_w - offset_w(line_w) - index_w(num_sets);
    endfunction

    // A single-way cache still needs a 1-bit way index.
    function automatic int age_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] word_mask(input int data_w);
        return (data_w >= MAX_DATA_W) ? {MAX_DATA_W{1'b1}}
                                      : ((MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1));
    endfunction

    function automatic logic [MAX_DATA_W-1:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                                       input int word_idx, input int data_w);
        return MAX_DATA_W'(line >> (word_idx * data_w)) & word_mask(data_w);
    endfunction

    function automatic logic [MAX_LINE_W-1:0] line_merge(input logic [MAX_LINE_W-1:0] line,
                                                         input logic [MAX_DATA_W-1:0] word,
                                                         input int word_idx, input int data_w);
        logic [MAX_LINE_W-1:0] mask;
        logic [MAX_LINE_W-1:0] wide;
        int sh;
        sh   = word_idx * data_w;
        mask = MAX_LINE_W'(word_mask(data_w)) << sh;
        wide = MAX_LINE_W'(word & word_mask(data_w)) << sh;
        return (line & ~mask) | wide;
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set tag/valid/dirty/data with a combinational read port
// and a single write port that always marks the entry valid.
module dcache_way_array #(
    parameter int LINE_W   = 256,
    parameter int TAG_W    = 23,
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_dirty,
    input  logic [LINE_W-1:0] wr_line
);

    logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_W-1:0] data_mem [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];

    // Only the status bits are reset; tag/data are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

endmodule

// File: rtl/dcache_sa_controller.sv
// N-way set-associative write-back/write-allocate data cache controller.
// Hits are combinational; misses stall the pipe through WB/FILL/UPD.
module dcache_sa_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LINE_W   = 256,
    parameter int NUM_WAYS = 2,
    parameter int NUM_SETS = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W  = offset_w(LINE_W);
    localparam int IDX_W  = index_w(NUM_SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, NUM_SETS);
    localparam int AGE_W  = age_w(NUM_WAYS);
    localparam int WAY_W  = AGE_W;
    localparam int WOFF_W = $clog2(DATA_W / 8);
    localparam int WSEL_W = OFF_W - WOFF_W;

    state_t            state_q;
    logic [WAY_W-1:0]  victim_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] word_idx;
    logic              req;
    logic              lookup;
    logic              unused_addr_bits;

    logic [NUM_WAYS-1:0] rd_valid;
    logic [NUM_WAYS-1:0] rd_dirty;
    logic [TAG_W-1:0]    rd_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   rd_line [NUM_WAYS];

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  victim;
    logic              victim_dirty;

    logic              fill_done;
    logic              store_hit;
    logic              wr_en;
    logic [WAY_W-1:0]  wr_way;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] merge_line;

    assign req_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign word_idx = cpu_addr_i[WOFF_W +: WSEL_W];
    assign unused_addr_bits = &{1'b0, cpu_addr_i[WOFF_W-1:0]};

    // A simultaneous read+write request is handled as a store.
    assign req    = cpu_MemRead_i | cpu_MemWrite_i;
    assign lookup = rst_i && req && (state_q == ST_IDLE || state_q == ST_UPD);

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_way_array #(
            .LINE_W   (LINE_W),
            .TAG_W    (TAG_W),
            .NUM_SETS (NUM_SETS),
            .IDX_W    (IDX_W)
        ) u_way (
            .clk      (clk_i),
            .rst_n    (rst_i),
            .rd_index (req_idx),
            .rd_tag   (rd_tag[w]),
            .rd_valid (rd_valid[w]),
            .rd_dirty (rd_dirty[w]),
            .rd_line  (rd_line[w]),
            .wr_en    (wr_en && (wr_way == WAY_W'(w))),
            .wr_index (req_idx),
            .wr_tag   (req_tag),
            .wr_dirty (!fill_done),
            .wr_line  (wr_line)
        );
    end

    // Lowest matching way wins; lowest invalid way is preferred as victim.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && rd_tag[w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        victim = lru_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) victim = WAY_W'(w);
        end
    end

    assign victim_dirty = rd_valid[victim] && rd_dirty[victim];
    assign hit_line     = rd_line[hit_way];
    assign merge_line   = LINE_W'(line_merge(MAX_LINE_W'(hit_line), MAX_DATA_W'(cpu_data_i),
                                             int'(word_idx), DATA_W));

    assign fill_done = (state_q == ST_FILL) && mem_ack_i;
    assign store_hit = lookup && hit && cpu_MemWrite_i;
    assign wr_en     = fill_done || store_hit;
    assign wr_way    = fill_done ? victim_q : hit_way;
    assign wr_line   = fill_done ? mem_data_i : merge_line;

    assign cpu_data_o  = (lookup && hit)
                         ? DATA_W'(word_sel(MAX_LINE_W'(hit_line), int'(word_idx), DATA_W))
                         : '0;
    assign cpu_stall_o = rst_i && ((state_q == ST_IDLE && req && !hit)
                                   || state_q == ST_WB || state_q == ST_FILL);

    assign mem_enable_o = (state_q == ST_WB) || (state_q == ST_FILL);
    assign mem_write_o  = (state_q == ST_WB);
    assign mem_data_o   = (state_q == ST_WB) ? rd_line[victim_q] : '0;

    always_comb begin
        mem_addr_o = '0;
        if (state_q == ST_WB)   mem_addr_o = {rd_tag[victim_q], req_idx, {OFF_W{1'b0}}};
        if (state_q == ST_FILL) mem_addr_o = {req_tag, req_idx, {OFF_W{1'b0}}};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            victim_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && !hit) begin
                        victim_q <= victim;
                        state_q  <= victim_dirty ? ST_WB : ST_FILL;
                    end
                end
                ST_WB:   if (mem_ack_i) state_q <= ST_FILL;
                ST_FILL: if (mem_ack_i) state_q <= ST_UPD;
                ST_UPD:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-set age counters: touched way becomes 0, younger ways age by one.
    if (NUM_WAYS > 1) begin : g_lru
        logic [AGE_W-1:0] age_q [NUM_SETS][NUM_WAYS];

        always_comb begin
            lru_way = '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[req_idx][w] == AGE_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        age_q[s][w] <= AGE_W'(w);
                    end
                end
            end else if (lookup && hit) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)
                        age_q[req_idx][w] <= '0;
                    else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                        age_q[req_idx][w] <= age_q[req_idx][w] + AGE_W'(1);
                end
            end
        end
    end else begin : g_no_lru
        assign lru_way = '0;
    end

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Bench for dcache_sa_controller: directed vector table, mid-fill reset,
// ignored ack, and a short random phase checked against a golden word model.
module tb_dcache_sa_controller;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    dcache_sa_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          rd;
        bit          wr;
        int          exp_stall;
        logic [31:0] wb_addr;
    } vec_t;

    int num_checks = 0;
    int num_pass   = 0;
    bit track_mem  = 1'b1;
    int mem_cnt    = 0;

    logic [31:0]  exp_q[$];
    logic [32:0]  mem_q[$];
    logic [31:0]  gold      [logic [31:0]];
    logic [255:0] mem_model [logic [31:0]];
    vec_t         vecs[21];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        num_checks++;
        if (act === exp) num_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] golden_word(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : pattern(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = golden_word(a + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [255:0] read_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = pattern(a + 32'(i * 4));
        return l;
    endfunction

    // Line memory: acks in the 4th cycle that mem_enable_o is seen high.
    always @(negedge clk_i) begin
        if (mem_enable_o) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == 4) begin
                mem_cnt   = 0;
                mem_ack_i = 1'b1;
                if (mem_write_o) begin
                    check($sformatf("wb_data@%h", mem_addr_o), mem_data_o, gold_line(mem_addr_o));
                    mem_model[mem_addr_o] = mem_data_o;
                end else begin
                    mem_data_i = read_line(mem_addr_o);
                end
                if (track_mem) begin
                    if (mem_q.size() == 0) begin
                        num_checks++;
                        $display("FAIL mem_op: unexpected op write=%0b addr=%h", mem_write_o, mem_addr_o);
                    end else begin
                        check("mem_op", {mem_write_o, mem_addr_o}, mem_q.pop_front());
                    end
                end
            end else begin
                mem_ack_i = 1'b0;
            end
        end else begin
            mem_cnt   = 0;
            mem_ack_i = 1'b0;
        end
    end

    // Starts at a falling edge, ends at a falling edge with the request dropped.
    task automatic access(input logic [31:0] addr, input logic [31:0] data, input bit rd,
                          input bit wr, output int stalls, output logic [31:0] rdata);
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        #1;
        stalls = 0;
        while (cpu_stall_o === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        if (stalls >= 200) begin
            num_checks++;
            $display("FAIL stall_timeout: addr=%h still stalled after %0d cycles", addr, stalls);
        end
        rdata = cpu_data_o;
        @(negedge clk_i);
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          stalls;
        logic [31:0] rdata;
        bit          load;
        load = v.rd && !v.wr;
        if (track_mem) begin
            if (v.exp_stall == 9) mem_q.push_back({1'b1, v.wb_addr});
            if (v.exp_stall >= 5) mem_q.push_back({1'b0, v.addr[31:5], 5'b0});
        end
        if (load) exp_q.push_back(golden_word(v.addr));
        access(v.addr, v.data, v.rd, v.wr, stalls, rdata);
        if (v.exp_stall >= 0) check($sformatf("stall_cycles@%h", v.addr), stalls, v.exp_stall);
        if (load) check($sformatf("load_data@%h", v.addr), rdata, exp_q.pop_front());
        else gold[v.addr] = v.data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        vec_t r;
        //         addr          data          rd wr stall wb_addr
        vecs[0]  = '{32'h040, 32'h0,        1, 0, 5, 32'h0};
        vecs[1]  = '{32'h040, 32'h0,        1, 0, 0, 32'h0};
        vecs[2]  = '{32'h05C, 32'h0,        1, 0, 0, 32'h0};
        vecs[3]  = '{32'h100, 32'h0,        1, 0, 5, 32'h0};
        vecs[4]  = '{32'h040, 32'h0,        1, 0, 5, 32'h0};
        vecs[5]  = '{32'h044, 32'hDEADBEEF, 0, 1, 0, 32'h0};
        vecs[6]  = '{32'h044, 32'h0,        1, 0, 0, 32'h0};
        vecs[7]  = '{32'h040, 32'h0,        1, 0, 0, 32'h0};
        vecs[8]  = '{32'h240, 32'h0,        1, 0, 5, 32'h0};
        vecs[9]  = '{32'h440, 32'h0,        1, 0, 9, 32'h040};
        vecs[10] = '{32'h044, 32'h0,        1, 0, 5, 32'h0};
        vecs[11] = '{32'h060, 32'h0,        1, 0, 5, 32'h0};
        vecs[12] = '{32'h260, 32'h0,        1, 0, 5, 32'h0};
        vecs[13] = '{32'h060, 32'h0,        1, 0, 0, 32'h0};
        vecs[14] = '{32'h460, 32'h0,        1, 0, 5, 32'h0};
        vecs[15] = '{32'h060, 32'h0,        1, 0, 0, 32'h0};
        vecs[16] = '{32'h260, 32'h0,        1, 0, 5, 32'h0};
        vecs[17] = '{32'h080, 32'h12345678, 1, 1, 5, 32'h0};
        vecs[18] = '{32'h080, 32'h0,        1, 0, 0, 32'h0};
        vecs[19] = '{32'h09C, 32'h0BADF00D, 0, 1, 0, 32'h0};
        vecs[20] = '{32'h09C, 32'h0,        1, 0, 0, 32'h0};

        rst_i          = 1'b0;
        cpu_addr_i     = 32'h40;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        #1;
        check("rst_stall", cpu_stall_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_mem_enable", mem_enable_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        @(negedge clk_i);
        cpu_MemRead_i = 1'b0;
        rst_i         = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Reset during the second FILL cycle abandons the refill.
        cpu_addr_i    = 32'h100;
        cpu_MemRead_i = 1'b1;
        #1;
        check("mid_miss_stall", cpu_stall_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("fill_enable", mem_enable_o, 1);
        check("fill_write", mem_write_o, 0);
        check("fill_addr", mem_addr_o, 32'h100);
        rst_i = 1'b0;
        #1;
        check("midrst_stall", cpu_stall_o, 0);
        check("midrst_cpu_data", cpu_data_o, 0);
        check("midrst_mem_enable", mem_enable_o, 0);
        check("midrst_mem_write", mem_write_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_mem_data", mem_data_o, 0);
        @(negedge clk_i);
        cpu_MemRead_i = 1'b0;
        rst_i         = 1'b1;
        @(negedge clk_i);

        for (int i = 3; i < 21; i++) run_vec(vecs[i]);

        // An ack pulse while idle must not start or disturb anything.
        cpu_addr_i    = 32'h080;
        cpu_MemRead_i = 1'b1;
        #1;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("ack_idle_enable", mem_enable_o, 0);
        check("ack_idle_stall", cpu_stall_o, 0);
        check("ack_idle_data", cpu_data_o, golden_word(32'h080));
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);

        track_mem = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r.addr      = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 1)) << 5)
                        | (32'($urandom_range(0, 7)) << 2);
            r.wr        = ($urandom_range(0, 2) == 0);
            r.rd        = !r.wr;
            r.data      = $urandom;
            r.exp_stall = -1;
            r.wb_addr   = '0;
            run_vec(r);
        end

        check("exp_q_drained", exp_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
